stat_seq_pipe_bench: RTL and testbench
======================================

// Module: stat_seq_pipe_bench
// PURPOSE
//  Parametrised sequential synthetic benchmark for the generated-circuit suite: an elastic
//  pipeline of STAGES registered nonlinear mixing layers over a WIDTH-bit word, fed through
//  an input accumulator that carries state between transactions. Gives the locking/attack
//  tooling a circuit with real state, stalls and a fully predictable golden model.
// PARAMETERS
//  WIDTH     32   datapath width; even, >= 4
//  STAGES    3    number of registered mixing stages; 1..8
//  SEED      0    reset/clear value of accumulator (low WIDTH bits used)
//  FEEDBACK  1    1: accumulator absorbs each accepted word; 0: accumulator frozen at SEED
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  clr        in   1      synchronous flush + accumulator/counter reload
//  in_valid   in   1      input word offered
//  in_ready   out  1      block can accept this cycle
//  in_data    in   WIDTH  input word
//  out_valid  out  1      result available
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  result word
//  state_out  out  WIDTH  current accumulator value
//  count      out  16     number of completed output transfers
// BEHAVIOUR
//  Reset (rst_n=0, async): all stage valids 0, stage data 0, acc=SEED, count=0.
//   Hence out_valid=0, out_data=0, state_out=SEED, in_ready=1 on first cycle after release.
//  Mixing function: g(x) = x ^ (rotl(x,1) & rotl(x,2)), rotl over WIDTH bits.
//  Stage 0 captures g(in_data ^ acc); stage k (k>=1) captures g(stage k-1 data).
//  out_data/out_valid are the last stage register directly (no combinational path to output).
//  Accept: in_valid && in_ready at a rising edge. On accept with FEEDBACK=1: acc <= acc ^ in_data
//   (stage 0 uses the pre-update acc). FEEDBACK=0: acc never changes except reset/clr.
//  Elastic handshake per stage: stage k may load when !valid_k || ready_{k+1};
//   ready after last stage = out_ready; in_ready = !valid_0 || ready_1 (combinational, no bubbles).
//  Throughput one word/cycle with out_ready held high.
//  Latency: word accepted at edge t shows out_valid=1 after edge t+STAGES-1 if no stall.
//  Stall: while out_valid && !out_ready, out_data and out_valid hold stable; bubbles collapse
//   upstream; once all stages full, in_ready=0. in_data ignored when in_ready=0.
//  Transfer: out_valid && out_ready at an edge -> count <= count+1, wraps 0xFFFF -> 0x0000.
//  clr=1 (highest priority after reset): at the edge, all valids <= 0, acc <= SEED, count <= 0;
//   in_ready=0 and no accept/transfer is counted in that cycle; in-flight words discarded.
//  Simultaneous accept and transfer in one cycle: both take effect; pipeline occupancy unchanged.
//  Reset asserted mid-stream: in-flight words lost immediately (async), no partial output.
//  Stage data registers load only with their valid (not every cycle); X-free after reset.
// TESTING (WIDTH=8, STAGES=3, SEED=0, FEEDBACK=1 unless noted)
//  1. Reset release, out_ready=1, in 0x03 at t -> out_data=0x0F valid after edge t+2; state_out=0x03.
//  2. Back-to-back 0x03,0x03 -> outputs 0x0F then 0x00 on consecutive cycles; count=2; state_out=0x00.
//  3. out_ready=0, stream 4 words -> 3 accepted, in_ready=0 on 4th; out_data stable at first result;
//     raise out_ready -> all 4 results drain in order, one per cycle, count=4.
//  4. FEEDBACK=0, SEED=0xFF, in 0x00 -> g^3(0xFF)=0x00 output; state_out stays 0xFF.
//  5. clr pulse with 2 words in flight -> out_valid=0 next cycle, count=0, state_out=SEED, no stale output.
//  6. 65536 transfers -> count wraps to 0x0000; rst_n pulse mid-stream -> out_valid=0 without clock edge.

Source files
------------

// File: rtl/stat_seq_pipe_bench.sv
// stat_seq_pipe_bench
// Elastic pipeline of registered nonlinear mixing stages over a WIDTH-bit word.
// An input accumulator is XORed into every accepted word before the first stage.
// Each stage applies g(x) = x ^ (rotl(x,1) & rotl(x,2)).
// A 16-bit counter tracks completed output transfers.
// Backpressure ripples combinationally from out_ready toward in_ready, so bubbles
// collapse without costing throughput.
module stat_seq_pipe_bench #(
    parameter int               WIDTH    = 32,
    parameter int               STAGES   = 3,
    parameter logic [WIDTH-1:0] SEED     = '0,
    parameter bit               FEEDBACK = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] state_out,
    output logic [15:0]      count
);

    // One mixing layer: each bit is flipped when its two lower neighbours
    // (cyclically) are both set.
    function automatic logic [WIDTH-1:0] mix(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] rot1;
        logic [WIDTH-1:0] rot2;
        rot1 = {x[WIDTH-2:0], x[WIDTH-1]};
        rot2 = {x[WIDTH-3:0], x[WIDTH-1 -: 2]};
        return x ^ (rot1 & rot2);
    endfunction

    // Per-stage views of the registers, plus what each stage would load next.
    logic             stage_valid [STAGES];
    logic [WIDTH-1:0] stage_data  [STAGES];
    logic             stage_ready [STAGES];
    logic             feed_valid  [STAGES];
    logic [WIDTH-1:0] feed_data   [STAGES];

    logic [WIDTH-1:0] acc_reg;
    logic [15:0]      count_reg;
    logic             accept;
    logic             transfer;

    // The ready chain runs from the output back to the input.
    // A stage can load when it is empty or when its contents move on this cycle.
    always_comb begin
        logic rdy;
        rdy = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy            = !stage_valid[k] || rdy;
            stage_ready[k] = rdy;
        end
    end

    // A flush cycle never accepts input and never counts a transfer.
    assign in_ready  = stage_ready[0] && !clr;
    assign accept    = in_valid && in_ready;
    assign transfer  = stage_valid[STAGES-1] && out_ready && !clr;

    // The output comes straight from the last stage register.
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];
    assign state_out = acc_reg;
    assign count     = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;

            if (gi == 0) begin : g_head
                // The head stage sees the input word whitened by the pre-update accumulator.
                assign feed_valid[gi] = in_valid;
                assign feed_data[gi]  = mix(in_data ^ acc_reg);
            end else begin : g_body
                assign feed_valid[gi] = stage_valid[gi-1];
                assign feed_data[gi]  = mix(stage_data[gi-1]);
            end

            // Stage register: flush on clr.
            // Otherwise advance when ready; data only loads when a valid word arrives.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (clr) begin
                    valid_reg <= 1'b0;
                end else if (stage_ready[gi]) begin
                    valid_reg <= feed_valid[gi];
                    if (feed_valid[gi]) begin
                        data_reg <= feed_data[gi];
                    end
                end
            end

            assign stage_valid[gi] = valid_reg;
            assign stage_data[gi]  = data_reg;
        end
    endgenerate

    // Accumulator: reloads SEED on clr.
    // When FEEDBACK is set, it also absorbs every accepted input word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= SEED;
        end else if (clr) begin
            acc_reg <= SEED;
        end else if (FEEDBACK && accept) begin
            acc_reg <= acc_reg ^ in_data;
        end
    end

    // Transfer counter: wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (transfer) begin
            count_reg <= count_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_stat_seq_pipe_bench.sv
// Bench for stat_seq_pipe_bench (WIDTH=8, STAGES=3).
// Main instance: SEED=0, FEEDBACK=1.
// Second instance: SEED=0xFF, FEEDBACK=0.
// A negedge monitor keeps a scoreboard of expected outputs for the main instance.
module tb_stat_seq_pipe_bench;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] state_out;
    logic [15:0] count;

    logic       clr2 = 1'b0;
    logic       in_valid2 = 1'b0;
    logic [7:0] in_data2 = 8'h00;
    logic       out_ready2 = 1'b1;
    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_data2;
    logic [7:0] state_out2;
    logic [15:0] count2;

    int          vectors = 0;
    int          miscompares = 0;
    bit          verbose = 1'b1;
    logic [7:0]  exp_q[$];
    logic [7:0]  m_acc = 8'h00;
    logic [15:0] m_count = 16'h0000;
    logic [7:0]  sb_exp;

    stat_seq_pipe_bench #(.WIDTH(8), .STAGES(3), .SEED(8'h00), .FEEDBACK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .state_out(state_out), .count(count)
    );

    stat_seq_pipe_bench #(.WIDTH(8), .STAGES(3), .SEED(8'hFF), .FEEDBACK(1'b0)) dut_nofb (
        .clk(clk), .rst_n(rst_n), .clr(clr2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .state_out(state_out2), .count(count2)
    );

    always #5 clk = ~clk;

    // Reference mixing layer, written bitwise: bit i flips when bits i-1 and i-2 are both set.
    function automatic logic [7:0] g_ref(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = x[i] ^ (x[(i + 7) % 8] & x[(i + 6) % 8]);
        end
        return y;
    endfunction

    function automatic logic [7:0] g3(input logic [7:0] x);
        return g_ref(g_ref(g_ref(x)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Scoreboard monitor: the values seen at a negedge are exactly what the next posedge samples.
    always @(negedge clk) begin
        if (!rst_n || clr) begin
            exp_q.delete();
            m_acc   = 8'h00;
            m_count = 16'h0000;
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_output got=%h want=<none>", out_data);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (verbose) $display("[%0t] xfer out=%h exp=%h", $time, out_data, sb_exp);
                    if (out_data !== sb_exp) begin
                        miscompares++;
                        $display("FAIL sb_out_data got=%h want=%h", out_data, sb_exp);
                    end
                end
                m_count = m_count + 16'd1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(g3(in_data ^ m_acc));
                if (verbose) $display("[%0t] accept in=%h acc=%h", $time, in_data, m_acc);
                m_acc = m_acc ^ in_data;
            end
        end
    end

    task automatic test_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({out_valid, out_data, state_out, count, in_ready} !== {1'b0, 8'h00, 8'h00, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state got v=%b d=%h s=%h c=%h r=%b want v=0 d=00 s=00 c=0000 r=1",
                     out_valid, out_data, state_out, count, in_ready);
        end
        vectors++;
        if (state_out2 !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_seed got=%h want=ff", state_out2);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_data  = 8'h03;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, state_out} !== {1'b0, 8'h03}) begin
            miscompares++;
            $display("FAIL single_t0 got v=%b s=%h want v=0 s=03", out_valid, state_out);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_t1 got v=%b want v=0", out_valid);
        end
        tick();
        vectors++;
        if ({out_valid, out_data} !== {1'b1, 8'h0F}) begin
            miscompares++;
            $display("FAIL single_t2 got v=%b d=%h want v=1 d=0f", out_valid, out_data);
        end
        tick();
        vectors++;
        if ({out_valid, count} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL single_done got v=%b c=%h want v=0 c=0001", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        in_valid = 1'b1;
        in_data  = 8'h03;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if ({out_valid, out_data} !== {1'b1, 8'h0F}) begin
            miscompares++;
            $display("FAIL b2b_first got v=%b d=%h want v=1 d=0f", out_valid, out_data);
        end
        tick();
        vectors++;
        if ({out_valid, out_data} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL b2b_second got v=%b d=%h want v=1 d=00", out_valid, out_data);
        end
        tick();
        vectors++;
        if ({out_valid, count, state_out} !== {1'b0, 16'd2, 8'h00}) begin
            miscompares++;
            $display("FAIL b2b_done got v=%b c=%h s=%h want v=0 c=0002 s=00", out_valid, count, state_out);
        end
    endtask

    task automatic test_stall();
        logic [7:0] w [4];
        logic [7:0] e [4];
        logic [7:0] a;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
        a = 8'h00;
        for (int i = 0; i < 4; i++) begin
            e[i] = g3(w[i] ^ a);
            a    = a ^ w[i];
        end
        do_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_fill_ready%0d got=%b want=1", i, in_ready);
            end
            tick();
        end
        in_data = w[3];
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_full_ready got=%b want=0", in_ready);
        end
        tick();
        tick();
        vectors++;
        if ({out_valid, out_data, state_out} !== {1'b1, e[0], 8'h00}) begin
            miscompares++;
            $display("FAIL stall_hold got v=%b d=%h s=%h want v=1 d=%h s=00", out_valid, out_data, state_out, e[0]);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_ready got=%b want=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if ({out_valid, out_data} !== {1'b1, e[i]}) begin
                miscompares++;
                $display("FAIL stall_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, e[i]);
            end
            tick();
        end
        vectors++;
        if ({out_valid, count} !== {1'b0, 16'd4}) begin
            miscompares++;
            $display("FAIL stall_done got v=%b c=%h want v=0 c=0004", out_valid, count);
        end
    endtask

    task automatic test_feedback_off();
        in_valid2 = 1'b1;
        in_data2  = 8'h00;
        tick();
        in_data2  = 8'h0F;
        tick();
        in_valid2 = 1'b0;
        vectors++;
        if (state_out2 !== 8'hFF) begin
            miscompares++;
            $display("FAIL nofb_state got=%h want=ff", state_out2);
        end
        tick();
        vectors++;
        if ({out_valid2, out_data2} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL nofb_first got v=%b d=%h want v=1 d=00", out_valid2, out_data2);
        end
        tick();
        vectors++;
        if ({out_valid2, out_data2, state_out2} !== {1'b1, g3(8'h0F ^ 8'hFF), 8'hFF}) begin
            miscompares++;
            $display("FAIL nofb_second got v=%b d=%h s=%h want v=1 d=%h s=ff",
                     out_valid2, out_data2, state_out2, g3(8'h0F ^ 8'hFF));
        end
        tick();
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        tick();
        in_data   = 8'h3C;
        tick();
        in_data   = 8'h77;
        clr       = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_in_ready got=%b want=0", in_ready);
        end
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, count, state_out} !== {1'b0, 16'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL clr_state got v=%b c=%h s=%h want v=0 c=0000 s=00", out_valid, count, state_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_stale%0d got v=%b want v=0", i, out_valid);
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        do_clr();
        verbose   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_ffff got=%h want=ffff", count);
        end
        verbose  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if ({count, m_count} !== {16'h0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL wrap_zero got=%h want=0000", count);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_valid got=%b want=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_data, count, state_out, in_ready} !== {1'b0, 8'h00, 16'h0000, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_async got v=%b d=%h c=%h s=%h r=%b want v=0 d=00 c=0000 s=00 r=1",
                     out_valid, out_data, count, state_out, in_ready);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after got v=%b want v=0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_feedback_off();
        test_clr();
        test_wrap_and_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
